fetch_sequencer: RTL and testbench

- Sequences instruction delivery for the 18-bit stack CPU.
- Owns the program counter and fetches from instruction memory over a req/ack handshake.
- Holds the fetched word in an instruction register and presents it to the combinational control unit and execute stage until execute signals completion.
- Applies taken jumps and halts the core on request.

---
 rtl/fetch_sequencer_if.sv | 75 +++++++
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Purpose:
//   Bundles the instruction-memory handshake and the execute-stage handshake
//   used by the fetch sequencer of the 18-bit stack CPU. The clock and reset
//   are kept as plain ports on the sequencer itself.
//
// Signals (names are from the sequencer's point of view):
//   o_imem_addr    PC_W     instruction memory address (mirrors o_pc)
//   o_imem_req     1        fetch request, held high until acknowledged
//   i_imem_ack     1        memory presents i_imem_data this cycle
//   i_imem_data    INSTR_W  fetched instruction word
//   o_instr        INSTR_W  instruction register, to the control unit
//   o_instr_valid  1        o_instr holds an instruction not yet executed
//   i_exec_done    1        execute has consumed o_instr this cycle
//   i_jump_taken   1        redirect the PC (only meaningful with i_exec_done)
//   i_jump_target  PC_W     redirect address
//   i_halt         1        stop after this instruction (with i_exec_done)
//   o_pc           PC_W     address of the instruction being fetched/issued
//   o_halted       1        sequencer is halted
//
// Modports:
//   master  - the fetch sequencer (drives the o_* signals)
//   slave   - memory / execute side (drives the i_* signals)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 18
);

    logic [PC_W-1:0]    o_imem_addr;
    logic               o_imem_req;
    logic               i_imem_ack;
    logic [INSTR_W-1:0] i_imem_data;
    logic [INSTR_W-1:0] o_instr;
    logic               o_instr_valid;
    logic               i_exec_done;
    logic               i_jump_taken;
    logic [PC_W-1:0]    i_jump_target;
    logic               i_halt;
    logic [PC_W-1:0]    o_pc;
    logic               o_halted;

    modport master (
        output o_imem_addr,
        output o_imem_req,
        input  i_imem_ack,
        input  i_imem_data,
        output o_instr,
        output o_instr_valid,
        input  i_exec_done,
        input  i_jump_taken,
        input  i_jump_target,
        input  i_halt,
        output o_pc,
        output o_halted
    );

    modport slave (
        input  o_imem_addr,
        input  o_imem_req,
        output i_imem_ack,
        output i_imem_data,
        input  o_instr,
        input  o_instr_valid,
        output i_exec_done,
        output i_jump_taken,
        output i_jump_target,
        output i_halt,
        input  o_pc,
        input  o_halted
    );

endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Instruction delivery for the 18-bit stack CPU. Owns the program counter,
//   fetches one word at a time from instruction memory over a req/ack
//   handshake, holds it in the instruction register until the execute stage
//   reports completion, then advances or redirects the PC. A halt request
//   parks the sequencer until reset.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset (release sampled on i_clk)
//   bus      fetch_sequencer_if.master - memory and execute handshakes
//
// Parameters:
//   PC_W      program counter / instruction address width
//   INSTR_W   instruction word width
//   RESET_PC  PC loaded on reset
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 18,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic              i_clk,
    input logic              i_rst_n,
    fetch_sequencer_if.master bus
);

    // BOOT   : single idle cycle after reset so memory sees no request
    // FETCH  : request outstanding at the current PC
    // ISSUE  : instruction register valid, waiting for execute
    // HALT   : parked until reset
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pcNext;
    logic               w_pcLoad;
    logic [INSTR_W-1:0] r_instr;
    logic               w_instrLoad;
    logic               w_req;
    logic               w_valid;
    logic               w_halted;
    logic               w_ackAccepted;
    logic               w_execAccepted;

    // Handshake qualifiers: an ack only counts while a fetch is outstanding,
    // and execute completion only counts while an instruction is issued.
    // Everything else on those inputs is ignored by construction.
    assign w_ackAccepted  = (r_state == ST_FETCH) && bus.i_imem_ack;
    assign w_execAccepted = (r_state == ST_ISSUE) && bus.i_exec_done;

    // State register. Reset forces BOOT asynchronously so the request and
    // valid outputs, which decode straight from the state, drop at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and output decode. Outputs depend only on the current
    // state, so they behave as registered signals: valid rises the cycle
    // after the accepting ack, req rises the cycle after leaving ISSUE.
    always_comb begin
        w_stateNext = r_state;
        w_pcLoad    = 1'b0;
        w_pcNext    = r_pc;
        w_instrLoad = 1'b0;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        w_halted    = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_stateNext = ST_FETCH;
            end

            ST_FETCH: begin
                w_req = 1'b1;
                if (w_ackAccepted) begin
                    w_instrLoad = 1'b1;
                    w_stateNext = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                w_valid = 1'b1;
                if (w_execAccepted) begin
                    // Halt and jump are independent: a halting jump still
                    // records its target so the resume address is visible.
                    w_pcLoad    = 1'b1;
                    w_pcNext    = bus.i_jump_taken ? bus.i_jump_target
                                                   : r_pc + PC_W'(1);
                    w_stateNext = bus.i_halt ? ST_HALT : ST_FETCH;
                end
            end

            ST_HALT: begin
                w_halted = 1'b1;
            end

            default: begin
                w_stateNext = ST_BOOT;
            end
        endcase
    end

    // Program counter. Increment wraps modulo 2^PC_W with no flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_pcLoad) begin
            r_pc <= w_pcNext;
        end
    end

    // Instruction register. Only an accepted ack writes it, so the word
    // survives FETCH and HALT unchanged even though it is then not valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr <= '0;
        end else if (w_instrLoad) begin
            r_instr <= bus.i_imem_data;
        end
    end

    assign bus.o_imem_addr   = r_pc;
    assign bus.o_pc          = r_pc;
    assign bus.o_imem_req    = w_req;
    assign bus.o_instr       = r_instr;
    assign bus.o_instr_valid = w_valid;
    assign bus.o_halted      = w_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Purpose:
//   Self-checking bench for fetch_sequencer. A transaction-level model of the
//   sequencer runs alongside the DUT and every output is compared against it
//   on each falling clock edge; directed scenarios add literal expectations.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic clk  = 1'b0;
    logic rstN = 1'b1;

    int vecCount  = 0;
    int missCount = 0;

    fetch_sequencer_if #(.PC_W(16), .INSTR_W(18)) bus ();

    fetch_sequencer #(
        .PC_W    (16),
        .INSTR_W (18),
        .RESET_PC(16'h0000)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rstN),
        .bus    (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Model state, described in terms of what the sequencer is doing:
    // idle after reset, waiting on memory, holding an instruction for
    // execute, or parked after a halt.
    logic        mBoot;
    logic        mWaiting;
    logic        mHolding;
    logic        mHalted;
    logic [15:0] mPc;
    logic [17:0] mInstr;

    // Model update: the rules of the sequencer applied once per clock,
    // with reset taking effect the moment it is asserted.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mBoot    <= 1'b1;
            mWaiting <= 1'b0;
            mHolding <= 1'b0;
            mHalted  <= 1'b0;
            mPc      <= 16'h0000;
            mInstr   <= 18'h0;
        end else if (mBoot) begin
            mBoot    <= 1'b0;
            mWaiting <= 1'b1;
        end else if (mWaiting && bus.i_imem_ack) begin
            mInstr   <= bus.i_imem_data;
            mWaiting <= 1'b0;
            mHolding <= 1'b1;
        end else if (mHolding && bus.i_exec_done) begin
            mPc      <= bus.i_jump_taken ? bus.i_jump_target : mPc + 16'd1;
            mHolding <= 1'b0;
            if (bus.i_halt) mHalted  <= 1'b1;
            else            mWaiting <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Compare process: every output against the model on each falling edge,
    // well away from the rising edge where the DUT updates.
    always @(negedge clk) begin
        checkOutput("model req",    32'(bus.o_imem_req),    32'(mWaiting));
        checkOutput("model valid",  32'(bus.o_instr_valid), 32'(mHolding));
        checkOutput("model halted", 32'(bus.o_halted),      32'(mHalted));
        checkOutput("model pc",     32'(bus.o_pc),          32'(mPc));
        checkOutput("model addr",   32'(bus.o_imem_addr),   32'(mPc));
        checkOutput("model instr",  32'(bus.o_instr),       32'(mInstr));
    end

    // Drive one cycle of inputs, cross the rising edge, return 1ns after it.
    task automatic applyStimulus(input logic ack, input logic [17:0] data,
                                 input logic done, input logic jump,
                                 input logic [15:0] target, input logic halt);
        bus.i_imem_ack    = ack;
        bus.i_imem_data   = data;
        bus.i_exec_done   = done;
        bus.i_jump_taken  = jump;
        bus.i_jump_target = target;
        bus.i_halt        = halt;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    // Hold reset across one rising edge and release it mid-cycle, leaving the
    // caller in the BOOT cycle.
    task automatic finishReset();
        @(posedge clk);
        #1;
        #2 rstN = 1'b1;
    endtask

    // Directed scenarios with literal expectations.
    initial begin
        bus.i_imem_ack    = 1'b0;
        bus.i_imem_data   = 18'h0;
        bus.i_exec_done   = 1'b0;
        bus.i_jump_taken  = 1'b0;
        bus.i_jump_target = 16'h0;
        bus.i_halt        = 1'b0;

        // Power-on reset, checked before any clock edge.
        #1 rstN = 1'b0;
        #1;
        checkOutput("reset req",    32'(bus.o_imem_req),    32'h0);
        checkOutput("reset valid",  32'(bus.o_instr_valid), 32'h0);
        checkOutput("reset halted", 32'(bus.o_halted),      32'h0);
        checkOutput("reset pc",     32'(bus.o_pc),          32'h0);
        checkOutput("reset instr",  32'(bus.o_instr),       32'h0);
        finishReset();
        checkOutput("boot req", 32'(bus.o_imem_req), 32'h0);

        // Boot, then ack in the first FETCH cycle.
        idleCycle();
        checkOutput("fetch0 req",  32'(bus.o_imem_req),  32'h1);
        checkOutput("fetch0 addr", 32'(bus.o_imem_addr), 32'h0);
        applyStimulus(1'b1, 18'h12345, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("issue0 instr", 32'(bus.o_instr),       32'h12345);
        checkOutput("issue0 valid", 32'(bus.o_instr_valid), 32'h1);
        checkOutput("issue0 req",   32'(bus.o_imem_req),    32'h0);
        applyStimulus(1'b0, 18'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("done0 pc",    32'(bus.o_pc),          32'h1);
        checkOutput("done0 req",   32'(bus.o_imem_req),    32'h1);
        checkOutput("done0 valid", 32'(bus.o_instr_valid), 32'h0);

        // Ack delayed: request and address stable across the wait.
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("wait req",  32'(bus.o_imem_req),  32'h1);
            checkOutput("wait addr", 32'(bus.o_imem_addr), 32'h1);
        end
        applyStimulus(1'b1, 18'h2AAAA, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("late instr", 32'(bus.o_instr), 32'h2AAAA);
        applyStimulus(1'b1, 18'h3FFFF, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("spurious ack instr", 32'(bus.o_instr),       32'h2AAAA);
        checkOutput("spurious ack valid", 32'(bus.o_instr_valid), 32'h1);

        // Jump to 0x0040 then issue there.
        applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, 16'h0040, 1'b0);
        checkOutput("jump40 addr", 32'(bus.o_imem_addr), 32'h0040);
        applyStimulus(1'b1, 18'h00111, 1'b0, 1'b0, 16'h0, 1'b0);
        // Unqualified jump is ignored.
        applyStimulus(1'b0, 18'h0, 1'b0, 1'b1, 16'h0300, 1'b0);
        checkOutput("unqualified jump pc",    32'(bus.o_pc),          32'h0040);
        checkOutput("unqualified jump valid", 32'(bus.o_instr_valid), 32'h1);
        applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, 16'h0100, 1'b0);
        checkOutput("jump100 addr", 32'(bus.o_imem_addr), 32'h0100);
        checkOutput("jump100 req",  32'(bus.o_imem_req),  32'h1);

        // PC wrap from 0xFFFF.
        applyStimulus(1'b1, 18'h00222, 1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        checkOutput("jumpFFFF addr", 32'(bus.o_imem_addr), 32'hFFFF);
        applyStimulus(1'b1, 18'h00333, 1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 18'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("wrap addr", 32'(bus.o_imem_addr), 32'h0000);
        checkOutput("wrap req",  32'(bus.o_imem_req),  32'h1);

        // Execute-side inputs during FETCH are ignored.
        applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, 16'h0500, 1'b1);
        checkOutput("fetch ignores done pc",     32'(bus.o_pc),       32'h0000);
        checkOutput("fetch ignores done halted", 32'(bus.o_halted),   32'h0);
        checkOutput("fetch ignores done req",    32'(bus.o_imem_req), 32'h1);

        // Simultaneous halt and jump.
        applyStimulus(1'b1, 18'h00444, 1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, 16'h0200, 1'b1);
        checkOutput("halt halted", 32'(bus.o_halted),      32'h1);
        checkOutput("halt pc",     32'(bus.o_pc),          32'h0200);
        checkOutput("halt req",    32'(bus.o_imem_req),    32'h0);
        checkOutput("halt valid",  32'(bus.o_instr_valid), 32'h0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 18'($urandom), 1'b1, 1'b1, 16'h0777, 1'b0);
            checkOutput("halted req",    32'(bus.o_imem_req), 32'h0);
            checkOutput("halted halted", 32'(bus.o_halted),   32'h1);
            checkOutput("halted pc",     32'(bus.o_pc),       32'h0200);
        end

        // Reset leaves HALT and restores the PC.
        rstN = 1'b0;
        #1;
        checkOutput("unhalt pc",     32'(bus.o_pc),     32'h0);
        checkOutput("unhalt halted", 32'(bus.o_halted), 32'h0);
        bus.i_imem_ack  = 1'b0;
        bus.i_exec_done = 1'b0;
        finishReset();
        idleCycle();
        idleCycle();
        checkOutput("refetch req", 32'(bus.o_imem_req), 32'h1);

        // Reset mid-fetch with an ack about to arrive.
        rstN             = 1'b0;
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_data  = 18'h1ABCD;
        #1;
        checkOutput("async reset req",   32'(bus.o_imem_req),    32'h0);
        checkOutput("async reset valid", 32'(bus.o_instr_valid), 32'h0);
        finishReset();
        // Ack during the BOOT cycle after release is ignored.
        applyStimulus(1'b1, 18'h1ABCD, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("late ack instr", 32'(bus.o_instr),       32'h0);
        checkOutput("late ack valid", 32'(bus.o_instr_valid), 32'h0);
        checkOutput("late ack req",   32'(bus.o_imem_req),    32'h1);
        idleCycle();
        checkOutput("still fetching", 32'(bus.o_imem_req), 32'h1);

        // Reset mid-issue discards the instruction.
        applyStimulus(1'b1, 18'h0F0F0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("pre reset valid", 32'(bus.o_instr_valid), 32'h1);
        rstN           = 1'b0;
        bus.i_imem_ack = 1'b0;
        #1;
        checkOutput("issue reset valid", 32'(bus.o_instr_valid), 32'h0);
        checkOutput("issue reset instr", 32'(bus.o_instr),       32'h0);
        finishReset();
        idleCycle();
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
